// File: rtl/ls245_ctrl_pkg.sv
// ls245_ctrl_pkg: shared state, owner and direction encodings for the LS245 bus controller.
package ls245_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;
  localparam logic DIR_A_TO_B = 1'b1;
  localparam logic DIR_B_TO_A = 1'b0;
endpackage

// File: rtl/ls245_turn_timer.sv
// ls245_turn_timer: loadable down-counter; done marks the last cycle of the dead time.
module ls245_turn_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? value : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign done = cnt == W'(1);
endmodule

// File: rtl/ls245_bus_ctrl.sv
// ls245_bus_ctrl: break-before-make DIR/OE sequencer sharing one LS245 between an A-side and a B-side master.
module ls245_bus_ctrl
  import ls245_ctrl_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_MAX    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic inhibit,
  output logic gnt_a,
  output logic gnt_b,
  output logic dir,
  output logic oe,
  output logic busy
);
  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("TURN_CYCLES must be 1..15");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be 1..255");
  end
  state_t     state, state_nxt;
  owner_t     owner, owner_nxt, last_owner, last_nxt;
  logic       dir_nxt, own_req, oth_req, turn_done;
  logic [7:0] hold, hold_inc;
  assign own_req  = owner == OWN_A ? req_a : req_b;
  assign oth_req  = owner == OWN_A ? req_b : req_a;
  // hold_inc counts the current ACTIVE cycle, so pre-emption lands after exactly HOLD_MAX cycles
  assign hold_inc = hold == 8'(HOLD_MAX) ? hold : hold + 8'd1;
  ls245_turn_timer #(.W(4)) u_turn (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state_nxt == RELEASE && state != RELEASE),
    .value(4'(TURN_CYCLES)),
    .done (turn_done)
  );
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    dir_nxt   = dir;
    case (state)
      IDLE: if (!inhibit && (req_a || req_b)) begin
        state_nxt = SETUP;
        owner_nxt = (req_a && req_b) ? (last_owner == OWN_A ? OWN_B : OWN_A) : (req_a ? OWN_A : OWN_B);
        dir_nxt   = owner_nxt == OWN_A ? DIR_A_TO_B : DIR_B_TO_A;
      end
      SETUP: if (inhibit || !own_req) begin
        state_nxt = RELEASE;
        last_nxt  = owner;
      end else state_nxt = ACTIVE;
      ACTIVE: if (inhibit || !own_req || (hold_inc == 8'(HOLD_MAX) && oth_req)) begin
        state_nxt = RELEASE;
        last_nxt  = owner;
      end
      default: if (turn_done) state_nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      hold       <= '0;
      dir        <= DIR_A_TO_B;
      oe         <= 1'b1;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      hold       <= state == ACTIVE ? hold_inc : '0;
      dir        <= dir_nxt;
      oe         <= state_nxt != ACTIVE;
      gnt_a      <= state_nxt == ACTIVE && owner_nxt == OWN_A;
      gnt_b      <= state_nxt == ACTIVE && owner_nxt == OWN_B;
      busy       <= state_nxt != IDLE;
    end
endmodule

// File: tb/tb_ls245_bus_ctrl.sv
// tb_ls245_bus_ctrl: table-driven scoreboard bench for ls245_bus_ctrl (TURN_CYCLES=2, HOLD_MAX=4).
module tb_ls245_bus_ctrl;
  logic clk = 1'b0;
  logic rst_n, req_a, req_b, inhibit;
  logic gnt_a, gnt_b, dir, oe, busy;
  logic [4:0] outs;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic a;
    logic b;
    logic inh;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [4:0] sb[$];
  logic prev_dir = 1'b1;
  always #5 clk = ~clk;
  ls245_bus_ctrl #(.TURN_CYCLES(2), .HOLD_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .req_b  (req_b),
    .inhibit(inhibit),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .dir    (dir),
    .oe     (oe),
    .busy   (busy)
  );
  // {gnt_a, gnt_b, dir, oe, busy}
  assign outs = {gnt_a, gnt_b, dir, oe, busy};
  function automatic void add(logic a, logic b, logic inh, logic [4:0] e);
    vec_t v;
    v.a = a;
    v.b = b;
    v.inh = inh;
    v.exp = e;
    vecs.push_back(v);
  endfunction
  task automatic check(string name, logic [4:0] act);
    logic [4:0] exp;
    exp = sb.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gnt_a,gnt_b,dir,oe,busy=%b want %b", name, act, exp);
    end
  endtask
  task automatic step(logic a, logic b, logic inh, logic [4:0] e, string name);
    req_a = a;
    req_b = b;
    inhibit = inh;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check(name, outs);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      a_dir: assert (oe || dir == prev_dir) else begin
        bad++;
        $display("FAIL inv_dir_stable: dir %b prev %b with oe=0", dir, prev_dir);
      end
      a_excl: assert (!(gnt_a && gnt_b)) else begin
        bad++;
        $display("FAIL inv_grant_excl: gnt_a=%b gnt_b=%b", gnt_a, gnt_b);
      end
      a_gnt_oe: assert (!(gnt_a || gnt_b) || !oe) else begin
        bad++;
        $display("FAIL inv_grant_oe: grant high with oe=%b", oe);
      end
      a_oe_gnt: assert (oe || gnt_a || gnt_b) else begin
        bad++;
        $display("FAIL inv_oe_grant: oe=0 without grant");
      end
    end
    prev_dir <= dir;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    inhibit = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(5'b00110);
    check("reset", outs);
    rst_n = 1'b1;
    add(0, 0, 0, 5'b00110);
    add(1, 0, 0, 5'b00111);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 5'b10101);
    add(0, 0, 0, 5'b00111);
    add(0, 0, 0, 5'b00111);
    add(0, 0, 0, 5'b00110);
    add(1, 1, 0, 5'b00011);
    for (int k = 0; k < 4; k++) add(1, 1, 0, 5'b01001);
    add(1, 1, 0, 5'b00011);
    add(1, 1, 0, 5'b00011);
    add(1, 1, 0, 5'b00010);
    add(1, 1, 0, 5'b00111);
    for (int k = 0; k < 4; k++) add(1, 1, 0, 5'b10101);
    add(1, 1, 0, 5'b00111);
    add(1, 1, 0, 5'b00111);
    add(1, 1, 0, 5'b00110);
    add(1, 1, 0, 5'b00011);
    add(1, 1, 0, 5'b01001);
    add(1, 0, 0, 5'b00011);
    add(1, 0, 0, 5'b00011);
    add(1, 0, 0, 5'b00010);
    add(1, 0, 0, 5'b00111);
    for (int k = 0; k < 21; k++) add(1, 0, 0, 5'b10101);
    add(1, 0, 1, 5'b00111);
    add(1, 0, 0, 5'b00111);
    add(1, 0, 0, 5'b00110);
    add(1, 0, 0, 5'b00111);
    add(1, 0, 1, 5'b00111);
    add(1, 0, 1, 5'b00111);
    add(1, 0, 1, 5'b00110);
    for (int k = 0; k < 4; k++) add(1, 1, 1, 5'b00110);
    add(0, 0, 0, 5'b00110);
    foreach (vecs[i]) step(vecs[i].a, vecs[i].b, vecs[i].inh, vecs[i].exp, $sformatf("vec%0d", i));
    step(1, 0, 0, 5'b00111, "pre_rst_setup");
    step(1, 0, 0, 5'b10101, "pre_rst_active");
    #2 rst_n = 1'b0;
    #1 sb.push_back(5'b00110);
    check("async_rst", outs);
    req_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 5'b00111, "post_rst_tie_setup");
    step(1, 1, 0, 5'b10101, "post_rst_tie_a");
    step(0, 0, 0, 5'b00111, "post_rst_release");
    step(0, 0, 0, 5'b00111, "post_rst_release2");
    step(0, 0, 0, 5'b00110, "post_rst_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
